// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - write/read handshake and status bundle for fifo_param
interface fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with occupancy, thresholds and error pulses
// FIFO_PARAM_FWFT_EN selects first-word-fall-through output instead of registered read data.
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AFULL_TH  = 2**ADDR_W - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic         clk,
  input  logic         srst,
  fifo_param_if.slave  bus
);
  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  if (!(AEMPTY_TH >= 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_th_check
    $fatal(1, "fifo_param: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, wr_ok, rd_ok;

  // A write at full is only legal because the simultaneous read frees the slot it lands in.
  always_comb begin
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    wr_ok       = bus.wr_en && (!full || bus.rd_en);
    rd_ok       = bus.rd_en && !empty;
    overflow_d  = bus.wr_en && full && !bus.rd_en;
    underflow_d = bus.rd_en && empty;
    wr_ptr_d    = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign bus.dout = mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign bus.dout = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
